// File: rtl/view_param_pkg.sv
// view_param_pkg: FSM states, angle wrap and button index constants for view_param_ctrl.
package view_param_pkg;
  typedef enum logic [1:0] {SCAN, COMMIT, BLANK} state_e;
  localparam int ANGLE_WRAP = 360;
  localparam int NEAR_INIT = 0;
  localparam int BTN_FAR_UP = 0;
  localparam int BTN_FAR_DN = 1;
  localparam int BTN_NEAR_UP = 2;
  localparam int BTN_NEAR_DN = 3;
  localparam int BTN_ROT_L = 4;
  localparam int BTN_ROT_R = 5;
endpackage

// File: rtl/view_param_ctrl_btn_repeat.sv
// btn_repeat: hold counter that emits one step pulse every REPEAT_CYCLES held cycles.
module btn_repeat #(
  parameter int REPEAT_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  output logic step_o
);
  localparam int CW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(REPEAT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign step_o = req_i && cnt_q == LAST;
  assign cnt_d = (!req_i || step_o) ? '0 : cnt_q + CW'(1);
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/view_param_ctrl.sv
// view_param_ctrl: button-driven angle/far/near shadow registers, committed to outputs once per frame.
module view_param_ctrl
  import view_param_pkg::*;
#(
  parameter int REPEAT_CYCLES = 100000,
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int FAR_MAX = 255,
  parameter int FAR_INIT = 17
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [5:0]  btn_in,
  output logic [15:0] angle_out,
  output logic [15:0] far_mag_out,
  output logic [15:0] near_mag_out,
  output logic        commit_out
);
  localparam logic [15:0] FMAX = 16'(FAR_MAX);
  localparam logic [15:0] FINIT = 16'(FAR_INIT);
  localparam logic [15:0] NINIT = 16'(NEAR_INIT);
  localparam logic [15:0] AMAX = 16'(ANGLE_WRAP - 1);
  localparam logic [9:0] V_END = 10'(V_ACTIVE);
  localparam bit H_OK = H_ACTIVE > 0;
  state_e state_q, state_d;
  logic [15:0] angle_q, angle_d, far_q, far_d, near_q, near_d;
  logic [15:0] aout_q, fout_q, nout_q;
  logic dirty_q, dirty_d, commit_q, commit;
  logic [5:0] pair_hold, step;
  // an opposing pair held together keeps both counters parked at zero
  assign pair_hold = {{2{&btn_in[5:4]}}, {2{&btn_in[3:2]}}, {2{&btn_in[1:0]}}};
  for (genvar i = 0; i < 6; i++) begin : g_btn
    btn_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_btn (
      .clk_i (pixel_clk_in),
      .rst_i (rst_in),
      .req_i (btn_in[i] && !pair_hold[i]),
      .step_o(step[i])
    );
  end
  assign commit = state_q == COMMIT && dirty_q;
  always_comb begin
    far_d = far_q + 16'(step[BTN_FAR_UP] && far_q < FMAX) - 16'(step[BTN_FAR_DN] && far_q > near_q);
    // near up is bounded by far after this cycle's far step
    near_d = near_q + 16'(step[BTN_NEAR_UP] && near_q + 16'd1 <= far_d)
           - 16'(step[BTN_NEAR_DN] && near_q != '0);
    angle_d = step[BTN_ROT_L] ? (angle_q == AMAX ? '0 : angle_q + 16'd1)
            : step[BTN_ROT_R] ? (angle_q == '0 ? AMAX : angle_q - 16'd1) : angle_q;
    dirty_d = {angle_d, far_d, near_d} != {angle_q, far_q, near_q} || (dirty_q && state_q != COMMIT);
    state_d = (state_q == SCAN && H_OK && vcount_in == V_END && hcount_in == '0) ? COMMIT
            : (state_q == COMMIT) ? BLANK
            : (state_q == BLANK && vcount_in == '0) ? SCAN : state_q;
  end
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q <= SCAN;
      angle_q <= '0;
      far_q <= FINIT;
      near_q <= NINIT;
      aout_q <= '0;
      fout_q <= FINIT;
      nout_q <= NINIT;
      dirty_q <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      far_q <= far_d;
      near_q <= near_d;
      dirty_q <= dirty_d;
      commit_q <= commit;
      if (commit) begin
        aout_q <= angle_q;
        fout_q <= far_q;
        nout_q <= near_q;
      end
    end
  end
  assign angle_out = aout_q;
  assign far_mag_out = fout_q;
  assign near_mag_out = nout_q;
  assign commit_out = commit_q;
endmodule
